// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package serial_add_pkg;

    localparam int SA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

endpackage

// File: rtl/fa.sv
// Single-bit combinational full-adder cell, the only arithmetic element used by
// the serial adder datapath.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell per clock, LSB first, WIDTH+1 cycles from
// accepted start to done. Optional subtract mode enabled by SERIAL_ADD_SUB_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    sa_state_t        state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_s;
    logic             bit_c;

    fa u_fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .sum  (bit_s),
        .cout (bit_c)
    );

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: invert B and force the initial carry to 1.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    // Result bits enter from the MSB end so the LSB-first stream lands aligned.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = bit_s;
        end else begin : g_res_wn
            assign res_next = {bit_s, res[WIDTH-1:1]};
        end
    endgenerate

    // NOTE: every register here is state, so all use non-blocking assignment;
    // blocking would let later statements see same-edge updates and break the
    // shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa   <= a;
                        opb   <= b_load;
                        carry <= c_load;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= bit_c;
                    res   <= res_next;
                    cnt   <= cnt + CW'(1);
                    // Visible result only changes here, so no partial sums leak out.
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        cout  <= bit_c;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
